// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   FWD_*      : forward-select encoding returned to the decode operand muxes
//   fsm_state_e: load-use stall FSM states
//   shadow_t   : one in-flight instruction tracked by the shadow pipeline
//   stage_hit  : does a shadow stage supply the register a decode source reads
package hazard_pkg;

   // Widest register address the shadow stages can hold; narrower
   // addresses are zero-extended into it.
   localparam int unsigned SHADOW_AW = 8;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } fsm_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 we;
      logic [SHADOW_AW-1:0] wa;
      logic                 is_load;
   } shadow_t;

   // x0 is hard-wired zero, so a write to it never forwards.
   function automatic logic stage_hit(input shadow_t              st,
                                      input logic [SHADOW_AW-1:0] ra,
                                      input logic                 used);
      return st.valid && st.we && (st.wa != '0) && (st.wa == ra) && used;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source forwarding comparator over the EX/MEM/WB shadow stages.
//   ex_st/mem_st/wb_st : shadow stage contents (distance 1/2/3 from ID)
//   ra, used           : source register address and read intent
//   sel_c              : forward select, EX > MEM > WB > regfile
//   blocked_c          : chosen stage holds a load whose data is not yet
//                        on a forward path
//   need_c             : stall cycles required while blocked (0 otherwise)
module fwd_match
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned LOAD_FWD_STAGE = 1
) (
   input  shadow_t           ex_st,
   input  shadow_t           mem_st,
   input  shadow_t           wb_st,
   input  logic [REG_AW-1:0] ra,
   input  logic              used,
   output logic [1:0]        sel_c,
   output logic              blocked_c,
   output logic [1:0]        need_c
);

   shadow_t              stg [3];
   logic [SHADOW_AW-1:0] ra_ext;
   logic                 found;

   // Youngest matching stage wins; a load in a stage closer to ID than the
   // load forward path blocks instead of forwarding.
   always_comb begin
      sel_c     = FWD_REG;
      blocked_c = 1'b0;
      need_c    = 2'd0;
      found     = 1'b0;
      ra_ext    = SHADOW_AW'(ra);
      stg[0]    = ex_st;
      stg[1]    = mem_st;
      stg[2]    = wb_st;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!found && stage_hit(stg[i], ra_ext, used)) begin
            found = 1'b1;
            sel_c = 2'(i + 1);
            // distance = i+1; stall length = LOAD_FWD_STAGE + 1 - distance
            if (stg[i].is_load && (i + 1 <= LOAD_FWD_STAGE)) begin
               blocked_c = 1'b1;
               need_c    = 2'(LOAD_FWD_STAGE - i);
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks in-flight destinations in its own EX/MEM/WB shadow pipeline and
// returns operand forward selects plus load-use stall/bubble controls.
//   clk, rst_n          : clock, async active-low reset
//   id_valid            : decode holds a real instruction
//   id_ra1/id_ra2       : source addresses; id_rs1_used/id_rs2_used read intent
//   id_we/id_wa         : decode destination write
//   id_is_load          : decode instruction is a load
//   flush               : branch mispredict, kill the ID instruction
//   mem_hold            : dmem back-pressure, freeze everything
//   sel_ra1/sel_ra2     : forward selects (0 regfile, 1 EX, 2 MEM, 3 WB)
//   stall_if/stall_id   : hold PC/IF and IF/ID
//   bubble_ex           : inject NOP into ID/EX
// LOAD_FWD_STAGE: 1 = load data first forwards from MEM, 2 = from WB.
// REG_AW must not exceed hazard_pkg::SHADOW_AW.
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_FWD_STAGE = 1,
   parameter int unsigned REG_AW         = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra1,
   input  logic [REG_AW-1:0] id_ra2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              id_we,
   input  logic [REG_AW-1:0] id_wa,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic              mem_hold,
   output logic [1:0]        sel_ra1,
   output logic [1:0]        sel_ra2,
   output logic              stall_if,
   output logic              stall_id,
   output logic              bubble_ex
);

   shadow_t    ex_q, mem_q, wb_q;
   shadow_t    ex_d;
   fsm_state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       flush_pend_q;
   logic       flush_eff_c;

   logic       blk1_c, blk2_c;
   logic [1:0] need1_c, need2_c;
   logic       hazard_c;
   logic [1:0] need_max_c;
   logic       min_stall_c;

   fwd_match #(
      .REG_AW        (REG_AW),
      .LOAD_FWD_STAGE(LOAD_FWD_STAGE)
   ) u_match_rs1 (
      .ex_st    (ex_q),
      .mem_st   (mem_q),
      .wb_st    (wb_q),
      .ra       (id_ra1),
      .used     (id_rs1_used),
      .sel_c    (sel_ra1),
      .blocked_c(blk1_c),
      .need_c   (need1_c)
   );

   fwd_match #(
      .REG_AW        (REG_AW),
      .LOAD_FWD_STAGE(LOAD_FWD_STAGE)
   ) u_match_rs2 (
      .ex_st    (ex_q),
      .mem_st   (mem_q),
      .wb_st    (wb_q),
      .ra       (id_ra2),
      .used     (id_rs2_used),
      .sel_c    (sel_ra2),
      .blocked_c(blk2_c),
      .need_c   (need2_c)
   );

   // Both sources blocked: one stall of the longer length covers both.
   assign hazard_c    = blk1_c | blk2_c;
   assign need_max_c  = (need1_c > need2_c) ? need1_c : need2_c;
   // A flush that arrived under back-pressure takes effect once released.
   assign flush_eff_c = flush | flush_pend_q;

   // Stall FSM: next state and stall/bubble outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      bubble_ex   = 1'b0;
      min_stall_c = (state_q == ST_STALL) && (cnt_q != 2'd0);

      if (mem_hold) begin
         // Whole pipeline frozen; nothing may enter EX.
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else if (flush_eff_c) begin
         // Fetch redirect beats any stall; kill the ID instruction.
         bubble_ex = 1'b1;
         state_d   = ST_RUN;
         cnt_d     = 2'd0;
      end else begin
         if (hazard_c || min_stall_c) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end
         case (state_q)
            ST_RUN: begin
               if (hazard_c) begin
                  state_d = ST_STALL;
                  cnt_d   = need_max_c - 2'd1;
               end
            end
            ST_STALL: begin
               if (cnt_q != 2'd0) begin
                  cnt_d = cnt_q - 2'd1;
               end else if (hazard_c) begin
                  cnt_d = need_max_c - 2'd1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   // FSM state register; holds are encoded in the next-state logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Entry presented to EX on the next advance.
   always_comb begin
      ex_d = '0;
      if (id_valid && !bubble_ex && !flush_eff_c) begin
         ex_d.valid   = 1'b1;
         ex_d.we      = id_we;
         ex_d.wa      = SHADOW_AW'(id_wa);
         ex_d.is_load = id_is_load;
      end
   end

   // Shadow pipeline advances unless dmem back-pressure freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!mem_hold) begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Pending flush: captured while held, consumed on the first free cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend_q <= 1'b0;
      end else if (mem_hold) begin
         flush_pend_q <= flush_pend_q | flush;
      end else begin
         flush_pend_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: two instances (load forward
// from MEM and from WB) share one stimulus stream; each vector carries the
// expected outputs of both instances.
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load;
   logic [4:0] id_ra1, id_ra2, id_wa;
   logic       flush, mem_hold;

   logic [1:0] sel_ra1_1, sel_ra2_1, sel_ra1_2, sel_ra2_2;
   logic       stall_if_1, stall_id_1, bubble_ex_1;
   logic       stall_if_2, stall_id_2, bubble_ex_2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.LOAD_FWD_STAGE(1), .REG_AW(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_we(id_we), .id_wa(id_wa), .id_is_load(id_is_load),
      .flush(flush), .mem_hold(mem_hold),
      .sel_ra1(sel_ra1_1), .sel_ra2(sel_ra2_1),
      .stall_if(stall_if_1), .stall_id(stall_id_1), .bubble_ex(bubble_ex_1)
   );

   hazard_fwd_unit #(.LOAD_FWD_STAGE(2), .REG_AW(5)) dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_ra1(id_ra1), .id_ra2(id_ra2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_we(id_we), .id_wa(id_wa), .id_is_load(id_is_load),
      .flush(flush), .mem_hold(mem_hold),
      .sel_ra1(sel_ra1_2), .sel_ra2(sel_ra2_2),
      .stall_if(stall_if_2), .stall_id(stall_id_2), .bubble_ex(bubble_ex_2)
   );

   typedef struct {
      logic       v;
      logic [4:0] ra1, ra2;
      logic       u1, u2, we;
      logic [4:0] wa;
      logic       ld, fl, hd;
      logic [1:0] a1, a2;   // LOAD_FWD_STAGE=1 expected selects
      logic       ast, abb; // LOAD_FWD_STAGE=1 expected stall / bubble
      logic [1:0] b1, b2;   // LOAD_FWD_STAGE=2 expected selects
      logic       bst, bbb; // LOAD_FWD_STAGE=2 expected stall / bubble
   } vec_t;

   vec_t sb [$];
   vec_t tbl [40];

   function automatic vec_t mk(input logic v, input int ra1, input int ra2,
                               input logic u1, input logic u2, input logic we,
                               input int wa, input logic ld, input logic fl,
                               input logic hd,
                               input int a1, input int a2, input int ast, input int abb,
                               input int b1, input int b2, input int bst, input int bbb);
      vec_t r;
      r.v = v;  r.ra1 = 5'(ra1); r.ra2 = 5'(ra2);
      r.u1 = u1; r.u2 = u2; r.we = we; r.wa = 5'(wa);
      r.ld = ld; r.fl = fl; r.hd = hd;
      r.a1 = 2'(a1); r.a2 = 2'(a2); r.ast = 1'(ast); r.abb = 1'(abb);
      r.b1 = 2'(b1); r.b2 = 2'(b2); r.bst = 1'(bst); r.bbb = 1'(bbb);
      return r;
   endfunction

   task automatic cmp(input int idx, input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic cmp_all_zero(input int idx);
      cmp(idx, "rst sel_ra1_l1",   int'(sel_ra1_1),   0);
      cmp(idx, "rst sel_ra2_l1",   int'(sel_ra2_1),   0);
      cmp(idx, "rst stall_if_l1",  int'(stall_if_1),  0);
      cmp(idx, "rst stall_id_l1",  int'(stall_id_1),  0);
      cmp(idx, "rst bubble_ex_l1", int'(bubble_ex_1), 0);
      cmp(idx, "rst sel_ra1_l2",   int'(sel_ra1_2),   0);
      cmp(idx, "rst sel_ra2_l2",   int'(sel_ra2_2),   0);
      cmp(idx, "rst stall_if_l2",  int'(stall_if_2),  0);
      cmp(idx, "rst stall_id_l2",  int'(stall_id_2),  0);
      cmp(idx, "rst bubble_ex_l2", int'(bubble_ex_2), 0);
   endtask

   // Drive one decode cycle, queue its expectation, check at the negedge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      id_valid = v.v;   id_ra1 = v.ra1; id_ra2 = v.ra2;
      id_rs1_used = v.u1; id_rs2_used = v.u2;
      id_we = v.we; id_wa = v.wa; id_is_load = v.ld;
      flush = v.fl; mem_hold = v.hd;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      cmp(idx, "sel_ra1_l1",   int'(sel_ra1_1),   int'(e.a1));
      cmp(idx, "sel_ra2_l1",   int'(sel_ra2_1),   int'(e.a2));
      cmp(idx, "stall_if_l1",  int'(stall_if_1),  int'(e.ast));
      cmp(idx, "stall_id_l1",  int'(stall_id_1),  int'(e.ast));
      cmp(idx, "bubble_ex_l1", int'(bubble_ex_1), int'(e.abb));
      cmp(idx, "sel_ra1_l2",   int'(sel_ra1_2),   int'(e.b1));
      cmp(idx, "sel_ra2_l2",   int'(sel_ra2_2),   int'(e.b2));
      cmp(idx, "stall_if_l2",  int'(stall_if_2),  int'(e.bst));
      cmp(idx, "stall_id_l2",  int'(stall_id_2),  int'(e.bst));
      cmp(idx, "bubble_ex_l2", int'(bubble_ex_2), int'(e.bbb));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);

      //             v ra1 ra2 u1 u2 we wa ld fl hd | L1: s1 s2 st bb | L2: s1 s2 st bb
      tbl[0]  = idle;
      tbl[1]  = mk(1, 1, 2, 1, 1, 1, 5, 0, 0, 0,  0,0,0,0,  0,0,0,0); // add x5
      tbl[2]  = mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 0,  1,1,0,0,  1,1,0,0); // sub x6,x5,x5
      tbl[3]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0,0,0,0,  0,0,0,0); // x5 again
      tbl[4]  = mk(1, 5, 6, 1, 1, 1, 9, 0, 0, 0,  1,2,0,0,  1,2,0,0); // EX beats WB
      tbl[5]  = mk(1, 5, 6, 1, 0, 0, 0, 0, 0, 0,  2,0,0,0,  2,0,0,0); // rs2 unused
      tbl[6]  = mk(1, 5, 9, 1, 1, 0, 0, 0, 0, 0,  3,2,0,0,  3,2,0,0); // WB / MEM
      tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0,0,0,0,  0,0,0,0); // addi x0
      tbl[8]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0,0,0,0,  0,0,0,0); // read x0
      tbl[9]  = mk(1, 1, 0, 1, 0, 1, 7, 1, 0, 0,  0,0,0,0,  0,0,0,0); // lw x7
      tbl[10] = mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0,  1,0,1,1,  1,0,1,1); // add x8,x7,x1
      tbl[11] = mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0,  2,0,0,0,  2,0,1,1);
      tbl[12] = mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0,  3,0,0,0,  3,0,0,0);
      tbl[13] = idle; tbl[14] = idle; tbl[15] = idle;
      tbl[16] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0,0,0,0,  0,0,0,0); // lw x7
      tbl[17] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 0,  1,1,1,1,  1,1,1,1); // both sources
      tbl[18] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 1,  2,2,1,0,  2,2,1,0); // hold x3
      tbl[19] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 1,  2,2,1,0,  2,2,1,0);
      tbl[20] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 1,  2,2,1,0,  2,2,1,0);
      tbl[21] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 0,  2,2,0,0,  2,2,1,1); // resume
      tbl[22] = mk(1, 7, 7, 1, 1, 1, 8, 0, 0, 0,  3,3,0,0,  3,3,0,0);
      tbl[23] = idle; tbl[24] = idle; tbl[25] = idle;
      tbl[26] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0,0,0,0,  0,0,0,0); // lw x7
      tbl[27] = mk(1, 7, 1, 1, 1, 1, 8, 0, 1, 0,  1,0,0,1,  1,0,0,1); // flush at detect
      tbl[28] = mk(1, 8, 7, 1, 1, 0, 0, 0, 0, 0,  0,2,0,0,  0,2,1,1); // x8 killed
      tbl[29] = idle; tbl[30] = idle; tbl[31] = idle;
      tbl[32] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0,0,0,0,  0,0,0,0); // addi x9
      tbl[33] = mk(1, 9, 0, 1, 0, 0, 0, 0, 1, 1,  1,0,1,0,  1,0,1,0); // flush+hold
      tbl[34] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0,  1,0,0,1,  1,0,0,1); // pending flush
      tbl[35] = mk(1, 9, 0, 1, 0, 1,10, 0, 0, 0,  2,0,0,0,  2,0,0,0);
      tbl[36] = mk(1,10, 0, 1, 0, 0, 0, 0, 0, 0,  1,0,0,0,  1,0,0,0);
      tbl[37] = idle; tbl[38] = idle; tbl[39] = idle;

      rst_n = 1'b0;
      id_valid = 0; id_ra1 = 0; id_ra2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_we = 0; id_wa = 0; id_is_load = 0; flush = 0; mem_hold = 0;
      repeat (2) @(posedge clk);
      #1;
      cmp_all_zero(-1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) apply(tbl[i], i);

      // Async reset in the middle of a two-cycle load-use stall.
      apply(mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0,0,0,0,  0,0,0,0), 40);
      apply(mk(1, 7, 1, 1, 1, 1, 8, 0, 0, 0,  1,0,1,1,  1,0,1,1), 41);
      cmp(42, "pre-reset stall_if_l2", int'(stall_if_2), 1);
      cmp(42, "pre-reset sel_ra1_l1",  int'(sel_ra1_1),  2);
      #2;
      rst_n = 1'b0;
      #1;
      cmp_all_zero(43);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmp_all_zero(44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline. It consumes the decode stage's register addresses and write-back intent, and returns the forwarding selects the decode stage uses for its rs1/rs2 operand muxes.
- Keeps its own shadow pipeline of in-flight destinations (EX, MEM, WB) so it needs no taps from downstream stages.
- Generates load-use stalls and bubbles, honours branch-mispredict flushes, and freezes on data-memory back-pressure.

Parameters:
- LOAD_FWD_STAGE, 1, stage whose forward path first carries load data: 1 = MEM path (1-cycle load-use stall), 2 = WB path (2-cycle stall).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_ra1  in  REG_AW  rs1 address from decode.
- id_ra2  in  REG_AW  rs2 address from decode.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_we  in  1  decode register write enable.
- id_wa  in  REG_AW  decode destination address.
- id_is_load  in  1  instruction is a load (write data comes from dmem).
- flush  in  1  branch mispredict; kill the instruction in ID.
- mem_hold  in  1  dmem not ready; freeze whole pipeline.
- sel_ra1  out  2  rs1 forward select: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
- sel_ra2  out  2  rs2 forward select, same encoding.
- stall_if  out  1  hold PC/IF register.
- stall_id  out  1  hold IF/ID register.
- bubble_ex  out  1  inject NOP into ID/EX.

Behaviour:
- Shadow stages ex_*, mem_*, wb_*, each holding {valid, we, wa, is_load}. Reset: all zero; outputs sel = 0, stall_* = 0, bubble_ex = 0.
- Advance on every clk edge unless mem_hold:
  - wb <= mem, mem <= ex.
  - ex <= ID entry, or zero if bubble_ex or flush or !id_valid.
- mem_hold = 1: all shadow state, counters and FSM hold. stall_if = stall_id = 1 and bubble_ex = 0, combinationally, regardless of other inputs.
- A stage matches a source when: stage valid & we & wa != 0 & wa == id_raX & id_rsX_used.
- sel_raX, combinational: priority EX(1) > MEM(2) > WB(3) > 0. x0 never forwards (sel = 0).
- Load-use: a matching stage holding is_load, whose distance from ID is less than LOAD_FWD_STAGE + 1, blocks that stage's forward.
  - Distance: EX = 1, MEM = 2, WB = 3.
  - When LOAD_FWD_STAGE = 2, a load matched in MEM is also blocked.
  - A blocked match means stall_if = stall_id = bubble_ex = 1.
- FSM RUN/STALL with 2-bit counter cnt:
  - RUN -> STALL when a load-use block is detected and not flush. cnt <= required cycles − 1 (0 or 1).
  - STALL: outputs stall_if = stall_id = bubble_ex = 1. Decrement cnt each non-held cycle; return to RUN when cnt == 0 at a clock edge.
  - The stall condition is recomputed each cycle from shadow state. The FSM only guarantees a minimum length and never extends beyond what the hazard requires.
- flush: ex <= 0 on the next edge and the FSM forces RUN with cnt = 0. stall_* = 0 that cycle, because the fetch redirect has priority. bubble_ex = 1.
- flush and mem_hold together: mem_hold wins and the flush is held pending in a 1-bit register. It is applied on the first non-held cycle.
- Simultaneous rs1 and rs2 hazards: a single stall of the maximum required length.
- Async reset mid-stall: immediately RUN, all outputs 0.

Decomposition:
- Shared package hazard_pkg:
  - FWD_REG = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2, FWD_WB = 2'd3.
  - FSM state encoding.
  - Shadow-stage struct {valid, we, wa, is_load}.
- One sub-module, fwd_match: per-source combinational comparator over three stages that returns sel and a blocked flag. It is instantiated twice (rs1, rs2).

Test Plan:
- Forwarding and priority: `add x5` in EX, then `sub x6,x5,x5` in ID -> sel_ra1 = sel_ra2 = 1, no stall. With x5 written in both EX and WB -> sel = 1 (EX priority).
- x0 destination: `addi x0` in EX, then a reader of x0 -> sel = 0.
- Load-use, LOAD_FWD_STAGE = 1: `lw x7` then `add x8,x7,x1` -> exactly 1 cycle of stall_if/stall_id/bubble_ex = 1, then sel_ra1 = 2.
- Load-use, LOAD_FWD_STAGE = 2: same sequence -> 2 stall cycles, then sel_ra1 = 3.
- mem_hold during stall: assert mem_hold 3 cycles mid-stall -> stall held, cnt frozen, release resumes with the correct remaining count. Flush under hold -> applied on the first free cycle; ex cleared.
- Flush during load-use: flush in the detection cycle -> stall_* = 0, bubble_ex = 1, FSM stays RUN. Async rst_n low mid-STALL -> all outputs 0 immediately.
